// File: rtl/mux_pkg.sv
// Shared types and helpers for the scanning N-channel multiplexer.
package mux_pkg;

  typedef enum logic {
    S_MAN  = 1'b0,
    S_SCAN = 1'b1
  } state_t;

  localparam logic MODE_MAN  = 1'b0;
  localparam logic MODE_SCAN = 1'b1;

  // LSB position of channel idx inside the packed data bus.
  function automatic int unsigned slice_lsb(input int unsigned idx, input int unsigned w);
    return idx * w;
  endfunction

endpackage

// File: rtl/mux_scan_n_scan_seq.sv
// Dwell/channel counter pair for scan mode; flags the edge where the channel wraps.
module scan_seq #(
  parameter int N_CH  = 12,
  parameter int SEL_W = 4,
  parameter int DWELL = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  output logic [SEL_W-1:0] ch_cnt,
  output logic             wrapped
);

  localparam int DW_W = (DWELL > 1) ? $clog2(DWELL) : 1;

  logic [DW_W-1:0] dwell_cnt;

  // clr wins over en; with neither, the counters freeze (hold).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dwell_cnt <= '0;
      ch_cnt    <= '0;
      wrapped   <= 1'b0;
    end else if (clr) begin
      dwell_cnt <= '0;
      ch_cnt    <= '0;
      wrapped   <= 1'b0;
    end else if (en) begin
      wrapped <= 1'b0;
      if (dwell_cnt == DW_W'(DWELL - 1)) begin
        dwell_cnt <= '0;
        if (ch_cnt == SEL_W'(N_CH - 1)) begin
          ch_cnt  <= '0;
          wrapped <= 1'b1;
        end else begin
          ch_cnt <= ch_cnt + SEL_W'(1);
        end
      end else begin
        dwell_cnt <= dwell_cnt + DW_W'(1);
      end
    end
  end

endmodule

// File: rtl/mux_scan_n.sv
// Registered N-channel mux with manual select or a dwell-based channel scan.
module mux_scan_n
  import mux_pkg::*;
#(
  parameter int N_CH  = 12,
  parameter int W     = 4,
  parameter int SEL_W = 4,
  parameter int DWELL = 4
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic [N_CH*W-1:0] Din,
  input  logic [SEL_W-1:0]  Sin,
  input  logic              Mode,
  input  logic              Hold,
  output logic [W-1:0]      Dout,
  output logic [SEL_W-1:0]  Chan,
  output logic              Valid,
  output logic              Err,
  output logic              Frame
);

  state_t           state;
  state_t           state_nxt;
  logic [SEL_W-1:0] ch_cnt;
  logic             wrapped;
  logic             seq_en;
  logic             seq_clr;
  logic             sin_ok;
  logic [SEL_W-1:0] sel_idx;
  logic [W-1:0]     sel_data;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= S_MAN;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (!Hold) state_nxt = (Mode == MODE_SCAN) ? S_SCAN : S_MAN;
  end

  // Counters only run while scanning and staying in scan; any other unheld edge clears them.
  always_comb begin
    seq_en  = !Hold && (state == S_SCAN) && (state_nxt == S_SCAN);
    seq_clr = !Hold && !seq_en;
    sin_ok  = {1'b0, Sin} < (SEL_W + 1)'(N_CH);
    sel_idx = (state == S_SCAN) ? ch_cnt : Sin;
  end

  // Compare-and-select so an out-of-range index never addresses Din.
  always_comb begin
    sel_data = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (sel_idx == SEL_W'(k)) sel_data = Din[slice_lsb(k, W) +: W];
    end
  end

  scan_seq #(
    .N_CH  (N_CH),
    .SEL_W (SEL_W),
    .DWELL (DWELL)
  ) u_seq (
    .clk     (CLK),
    .rst_n   (nRST),
    .clr     (seq_clr),
    .en      (seq_en),
    .ch_cnt  (ch_cnt),
    .wrapped (wrapped)
  );

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      Dout  <= '0;
      Chan  <= '0;
      Valid <= 1'b0;
      Err   <= 1'b0;
      Frame <= 1'b0;
    end else if (Hold) begin
      Frame <= 1'b0;
    end else if (state == S_SCAN) begin
      Dout  <= sel_data;
      Chan  <= ch_cnt;
      Valid <= 1'b1;
      Err   <= 1'b0;
      Frame <= wrapped;
    end else begin
      Frame <= 1'b0;
      if (sin_ok) begin
        Dout  <= sel_data;
        Chan  <= Sin;
        Valid <= 1'b1;
        Err   <= 1'b0;
      end else begin
        Valid <= 1'b0;
        Err   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mux_scan_n.sv
// Bench for mux_scan_n: behavioural frame-position model, every-cycle compare, directed literals, random run.
module tb_mux_scan_n;

  localparam int N_CH  = 12;
  localparam int W     = 4;
  localparam int SEL_W = 4;
  localparam int DWELL = 2;
  localparam int FRAME_LEN = N_CH * DWELL;

  logic              CLK = 1'b0;
  logic              nRST = 1'b0;
  logic [N_CH*W-1:0] Din;
  logic [SEL_W-1:0]  Sin = '0;
  logic              Mode = 1'b0;
  logic              Hold = 1'b0;
  logic [W-1:0]      Dout;
  logic [SEL_W-1:0]  Chan;
  logic              Valid;
  logic              Err;
  logic              Frame;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] din_tab [N_CH] = '{4'h3, 4'h1, 4'hC, 4'h8, 4'h3, 4'h1, 4'h9, 4'h1, 4'h8, 4'h5, 4'hB, 4'h1};

  mux_scan_n #(.N_CH(N_CH), .W(W), .SEL_W(SEL_W), .DWELL(DWELL)) dut (
    .CLK(CLK), .nRST(nRST), .Din(Din), .Sin(Sin), .Mode(Mode), .Hold(Hold),
    .Dout(Dout), .Chan(Chan), .Valid(Valid), .Err(Err), .Frame(Frame)
  );

  // clock / reset
  always #5 CLK = ~CLK;

  // model: scan tracked as a single position within the frame (0..FRAME_LEN-1)
  bit           m_scan = 0;
  bit           m_pend = 0;
  int           m_pos = 0;
  logic [W-1:0] m_dout = '0;
  logic [SEL_W-1:0] m_chan = '0;
  logic         m_valid = 0, m_err = 0, m_frame = 0;

  function automatic logic [W-1:0] din_of(input logic [N_CH*W-1:0] bus, input int idx);
    return bus[idx*W +: W];
  endfunction

  always @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      m_scan = 0; m_pend = 0; m_pos = 0;
      m_dout = '0; m_chan = '0; m_valid = 0; m_err = 0; m_frame = 0;
    end else if (Hold) begin
      m_frame = 0;
    end else begin
      if (m_scan) begin
        m_dout  = din_of(Din, m_pos / DWELL);
        m_chan  = SEL_W'(m_pos / DWELL);
        m_valid = 1; m_err = 0;
        m_frame = m_pend;
        if (Mode) begin
          m_pos++;
          m_pend = (m_pos == FRAME_LEN);
          if (m_pend) m_pos = 0;
        end else begin
          m_pos = 0; m_pend = 0;
        end
      end else begin
        m_frame = 0;
        if (int'(Sin) < N_CH) begin
          m_dout = din_of(Din, int'(Sin)); m_chan = Sin; m_valid = 1; m_err = 0;
        end else begin
          m_valid = 0; m_err = 1;
        end
        m_pos = 0; m_pend = 0;
      end
      m_scan = Mode;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboard: every negedge, outputs against the model
  always @(negedge CLK) begin
    check("cyc_dout",  32'(Dout),  32'(m_dout));
    check("cyc_chan",  32'(Chan),  32'(m_chan));
    check("cyc_valid", 32'(Valid), 32'(m_valid));
    check("cyc_err",   32'(Err),   32'(m_err));
    check("cyc_frame", 32'(Frame), 32'(m_frame));
  end

  // driver tasks
  task automatic step(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic load_table();
    for (int k = 0; k < N_CH; k++) Din[k*W +: W] = din_tab[k];
  endtask

  initial begin
    int n;
    int frames_seen;
    load_table();
    step(2);
    check("rst_dout", 32'(Dout), 0);
    check("rst_valid", 32'(Valid), 0);
    check("rst_chan", 32'(Chan), 0);
    check("rst_err", 32'(Err), 0);
    check("rst_frame", 32'(Frame), 0);
    nRST = 1'b1;
    step(1);

    // manual select
    Sin = 4'd8; step(1);
    check("man_dout8", 32'(Dout), 32'h8);
    check("man_chan8", 32'(Chan), 8);
    check("man_valid", 32'(Valid), 1);
    check("man_err", 32'(Err), 0);
    Sin = 4'd2; step(1);
    check("man_dout2", 32'(Dout), 32'hC);
    Sin = 4'd8; step(1);
    Sin = 4'd13; step(1);
    check("oor_err", 32'(Err), 1);
    check("oor_valid", 32'(Valid), 0);
    check("oor_dout", 32'(Dout), 32'h8);
    check("oor_chan", 32'(Chan), 8);
    Sin = 4'd1; step(1);
    check("back_err", 32'(Err), 0);
    check("back_dout", 32'(Dout), 32'h1);

    // scan: one full frame of literal data
    Mode = 1'b1; step(1);
    for (int k = 0; k < N_CH; k++) begin
      exp_q.push_back(din_tab[k]);
      exp_q.push_back(din_tab[k]);
    end
    frames_seen = 0;
    for (int i = 0; i < FRAME_LEN; i++) begin
      logic [W-1:0] e;
      step(1);
      e = exp_q.pop_front();
      check("scan_seq", 32'(Dout), 32'(e));
      if (Frame === 1'b1) frames_seen++;
    end
    check("no_early_frame", frames_seen, 0);
    step(1);
    check("wrap_dout", 32'(Dout), 32'h3);
    check("wrap_frame", 32'(Frame), 1);

    // hold on ch4 dwell 0
    step(8);
    check("pre_hold_chan", 32'(Chan), 4);
    check("pre_hold_dout", 32'(Dout), 32'h3);
    Hold = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(1);
      check("hold_dout", 32'(Dout), 32'h3);
      check("hold_frame", 32'(Frame), 0);
    end
    Hold = 1'b0; step(1);
    check("resume_chan", 32'(Chan), 4);
    step(1);
    check("resume_next", 32'(Chan), 5);
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      step(1);
      if (Frame === 1'b1) begin n = i; break; end
    end
    check("delayed_wrap", n, 14);

    // async reset mid-scan at ch7
    step(14);
    check("pre_rst_chan", 32'(Chan), 7);
    #1 nRST = 1'b0;
    #1;
    check("arst_dout", 32'(Dout), 0);
    check("arst_valid", 32'(Valid), 0);
    check("arst_chan", 32'(Chan), 0);
    step(1);
    nRST = 1'b1; step(1);
    check("post_rst_manual", 32'(Chan), 1);
    step(1);
    check("restart_dout", 32'(Dout), 32'h3);
    check("restart_chan", 32'(Chan), 0);

    // scan -> manual -> scan
    Sin = 4'd5; Mode = 1'b0; step(1);
    check("leave_scan_chan", 32'(Chan), 0);
    step(1);
    check("man5_dout", 32'(Dout), 32'h1);
    check("man5_chan", 32'(Chan), 5);
    Mode = 1'b1; step(2);
    check("rescan_dout", 32'(Dout), 32'h3);
    check("rescan_frame", 32'(Frame), 0);

    // randomized run checked by the scoreboard
    for (int i = 0; i < 800; i++) begin
      Hold = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 39) == 0) Mode = ~Mode;
      Sin = SEL_W'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) Din = {$urandom, $urandom};
      if ($urandom_range(0, 199) == 0) begin
        #2 nRST = 1'b0;
        #2 nRST = 1'b1;
      end
      step(1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
